ecc_63_rd_stage: RTL and testbench

ECC_63_RD_STAGE -- requirements
Module: ecc_63_rd_stage

---
 rtl/ecc_63_rd_stage.sv | 153 +++++++++++++++
 tb/tb_ecc_63_rd_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ecc_63_rd_stage.sv
// Read-path stage after the ECC decoder: 2-entry skid buffer carrying data plus poison,
// with saturating error counters, first-error address capture and a sticky dbit interrupt.
module ecc_63_rd_stage #(
    parameter int unsigned DATA_WIDTH = 63,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sbit_err,
    input  logic                  in_dbit_err,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_poison,
    output logic [CNT_WIDTH-1:0]  sbit_cnt,
    output logic [CNT_WIDTH-1:0]  dbit_cnt,
    output logic                  err_addr_vld,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic                  err_is_dbit,
    output logic                  irq,
    input  logic                  clr
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};

    state_e                state_q, state_d;
    logic                  in_ready_q, out_valid_q;
    logic [DATA_WIDTH-1:0] head_data_q, skid_data_q;
    logic                  head_poison_q, skid_poison_q;
    logic [CNT_WIDTH-1:0]  sbit_cnt_q, sbit_cnt_d, dbit_cnt_q, dbit_cnt_d;
    logic                  err_vld_q, err_vld_d, err_dbit_q, err_dbit_d, irq_q, irq_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

    logic accept, deliver, sbit_hit, dbit_hit;

    always_comb begin
        accept   = in_valid & in_ready_q;
        deliver  = out_valid_q & out_ready;
        // A beat flagged both ways is uncorrectable; it never counts as sbit.
        dbit_hit = accept & in_dbit_err;
        sbit_hit = accept & in_sbit_err & ~in_dbit_err;

        state_d = state_q;
        unique case (state_q)
            StEmpty: if (accept) state_d = StOne;
            StOne: begin
                if (accept && !deliver) state_d = StTwo;
                else if (!accept && deliver) state_d = StEmpty;
            end
            StTwo: if (deliver) state_d = StOne;
            default: state_d = StEmpty;
        endcase
    end

    // clr is applied before this cycle's error so a coincident beat still counts.
    always_comb begin
        sbit_cnt_d = clr ? '0 : sbit_cnt_q;
        dbit_cnt_d = clr ? '0 : dbit_cnt_q;
        err_vld_d  = clr ? 1'b0 : err_vld_q;
        err_dbit_d = clr ? 1'b0 : err_dbit_q;
        irq_d      = clr ? 1'b0 : irq_q;
        err_addr_d = err_addr_q;

        if (sbit_hit && sbit_cnt_d != CntMax) sbit_cnt_d = sbit_cnt_d + 1'b1;
        if (dbit_hit && dbit_cnt_d != CntMax) dbit_cnt_d = dbit_cnt_d + 1'b1;

        if (dbit_hit) begin
            irq_d = 1'b1;
            if (!err_vld_d || !err_dbit_d) begin
                err_addr_d = in_addr;
                err_vld_d  = 1'b1;
                err_dbit_d = 1'b1;
            end
        end else if (sbit_hit && !err_vld_d) begin
            err_addr_d = in_addr;
            err_vld_d  = 1'b1;
            err_dbit_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StEmpty;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            head_data_q   <= '0;
            head_poison_q <= 1'b0;
            skid_data_q   <= '0;
            skid_poison_q <= 1'b0;
            sbit_cnt_q    <= '0;
            dbit_cnt_q    <= '0;
            err_vld_q     <= 1'b0;
            err_dbit_q    <= 1'b0;
            err_addr_q    <= '0;
            irq_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != StTwo);
            out_valid_q <= (state_d != StEmpty);

            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        head_data_q   <= in_data;
                        head_poison_q <= in_dbit_err;
                    end
                end
                StOne: begin
                    if (accept && deliver) begin
                        head_data_q   <= in_data;
                        head_poison_q <= in_dbit_err;
                    end else if (accept) begin
                        skid_data_q   <= in_data;
                        skid_poison_q <= in_dbit_err;
                    end
                end
                StTwo: begin
                    if (deliver) begin
                        head_data_q   <= skid_data_q;
                        head_poison_q <= skid_poison_q;
                    end
                end
                default: ;
            endcase

            sbit_cnt_q <= sbit_cnt_d;
            dbit_cnt_q <= dbit_cnt_d;
            err_vld_q  <= err_vld_d;
            err_dbit_q <= err_dbit_d;
            err_addr_q <= err_addr_d;
            irq_q      <= irq_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_data     = head_data_q;
    assign out_poison   = head_poison_q;
    assign sbit_cnt     = sbit_cnt_q;
    assign dbit_cnt     = dbit_cnt_q;
    assign err_addr_vld = err_vld_q;
    assign err_addr     = err_addr_q;
    assign err_is_dbit  = err_dbit_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_ecc_63_rd_stage.sv
// Directed bench for ecc_63_rd_stage; built with 4-bit counters so saturation is reachable.
module tb_ecc_63_rd_stage;

    localparam int unsigned DW = 63;
    localparam int unsigned AW = 8;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, in_sbit_err, in_dbit_err;
    logic [DW-1:0] in_data, out_data;
    logic [AW-1:0] in_addr, err_addr;
    logic          out_valid, out_ready, out_poison, err_addr_vld, err_is_dbit, irq, clr;
    logic [CW-1:0] sbit_cnt, dbit_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    ecc_63_rd_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_sbit_err  (in_sbit_err),
        .in_dbit_err  (in_dbit_err),
        .in_addr      (in_addr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_poison   (out_poison),
        .sbit_cnt     (sbit_cnt),
        .dbit_cnt     (dbit_cnt),
        .err_addr_vld (err_addr_vld),
        .err_addr     (err_addr),
        .err_is_dbit  (err_is_dbit),
        .irq          (irq),
        .clr          (clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic v, input logic [DW-1:0] d, input logic sb, input logic db,
                        input logic [AW-1:0] a);
        in_valid    = v;
        in_data     = d;
        in_sbit_err = sb;
        in_dbit_err = db;
        in_addr     = a;
    endtask

    function automatic logic [DW-1:0] mk(input int i);
        logic [31:0] lo;
        logic [30:0] hi;
        lo = 32'(i) ^ 32'hDEAD_BEEF;
        hi = 31'(i * 7 + 3);
        return {hi, lo};
    endfunction

    logic [DW-1:0] b1, b2, b3;

    initial begin
        rst = 1'b1; clr = 1'b0; out_ready = 1'b0;
        beat(1'b0, '0, 1'b0, 1'b0, '0);
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_poison", 64'(out_poison), 64'd0);
        chk("rst_cnts", 64'({sbit_cnt, dbit_cnt}), 64'd0);
        chk("rst_flags", 64'({err_addr_vld, err_is_dbit, irq}), 64'd0);
        chk("rst_err_addr", 64'(err_addr), 64'd0);

        // Stream of 100 clean beats, one-cycle latency, in order
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            beat(1'b1, mk(i), 1'b0, 1'b0, 8'(i));
            tick();
            chk("stream_valid", 64'(out_valid), 64'd1);
            chk("stream_data", 64'(out_data), 64'(mk(i)));
        end
        beat(1'b0, '0, 1'b0, 1'b0, '0);
        tick();
        chk("stream_drain", 64'(out_valid), 64'd0);
        chk("stream_cnts", 64'({sbit_cnt, dbit_cnt}), 64'd0);

        // Backpressure
        b1 = 63'h1111_2222_3333_4444;
        b2 = 63'h5555_6666_7777_0001;
        b3 = 63'h0ABC_DEF0_1234_5678;
        out_ready = 1'b0;
        beat(1'b1, b1, 1'b0, 1'b0, 8'h01);
        tick();
        chk("bp_ready_one", 64'(in_ready), 64'd1);
        chk("bp_data_b1", 64'(out_data), 64'(b1));
        beat(1'b1, b2, 1'b0, 1'b0, 8'h02);
        tick();
        chk("bp_ready_two", 64'(in_ready), 64'd0);
        beat(1'b1, b3, 1'b0, 1'b0, 8'h03);
        tick();
        chk("bp_hold_data", 64'(out_data), 64'(b1));
        chk("bp_hold_ready", 64'(in_ready), 64'd0);
        tick();
        chk("bp_hold_data2", 64'(out_data), 64'(b1));
        out_ready = 1'b1;
        tick();
        chk("bp_out_b2", 64'(out_data), 64'(b2));
        chk("bp_out_b2_valid", 64'(out_valid), 64'd1);
        tick();
        beat(1'b0, '0, 1'b0, 1'b0, '0);
        chk("bp_out_b3", 64'(out_data), 64'(b3));
        tick();
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Error capture: sbit, dbit upgrade, later dbit ignored
        beat(1'b1, mk(1), 1'b1, 1'b0, 8'h12);
        tick();
        chk("cap1_poison", 64'(out_poison), 64'd0);
        chk("cap1_addr", 64'({err_addr_vld, err_is_dbit, err_addr}), 64'h212);
        chk("cap1_sbit", 64'(sbit_cnt), 64'd1);
        beat(1'b1, mk(2), 1'b0, 1'b1, 8'h34);
        tick();
        chk("cap2_poison", 64'(out_poison), 64'd1);
        chk("cap2_addr", 64'({err_addr_vld, err_is_dbit, err_addr}), 64'h334);
        chk("cap2_irq", 64'(irq), 64'd1);
        beat(1'b1, mk(3), 1'b0, 1'b1, 8'h56);
        tick();
        beat(1'b0, '0, 1'b0, 1'b0, '0);
        chk("cap3_poison", 64'(out_poison), 64'd1);
        chk("cap3_addr", 64'(err_addr), 64'h34);
        chk("cap3_cnts", 64'({sbit_cnt, dbit_cnt}), 64'h12);
        chk("cap3_irq", 64'(irq), 64'd1);

        // clr zeroes counters and flags, keeps the data path
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_cnts", 64'({sbit_cnt, dbit_cnt}), 64'd0);
        chk("clr_flags", 64'({err_addr_vld, err_is_dbit, irq}), 64'd0);
        chk("clr_out_valid", 64'(out_valid), 64'd0);

        // Both error flags: counted and captured as dbit only
        beat(1'b1, mk(4), 1'b1, 1'b1, 8'h20);
        tick();
        beat(1'b0, '0, 1'b0, 1'b0, '0);
        chk("both_cnts", 64'({sbit_cnt, dbit_cnt}), 64'h01);
        chk("both_cap", 64'({err_addr_vld, err_is_dbit, err_addr}), 64'h320);
        chk("both_poison", 64'(out_poison), 64'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;

        // Saturation at 2^4-1
        for (int i = 0; i < 20; i++) begin
            beat(1'b1, mk(i), 1'b1, 1'b0, 8'(8'h40 + i));
            tick();
        end
        beat(1'b0, '0, 1'b0, 1'b0, '0);
        chk("sat_sbit", 64'(sbit_cnt), 64'd15);
        chk("sat_cap", 64'({err_addr_vld, err_is_dbit, err_addr}), 64'h240);

        // clr coincident with an accepted dbit beat
        clr = 1'b1;
        beat(1'b1, mk(5), 1'b0, 1'b1, 8'h7F);
        tick();
        clr = 1'b0;
        beat(1'b0, '0, 1'b0, 1'b0, '0);
        chk("coll_cnts", 64'({sbit_cnt, dbit_cnt}), 64'h01);
        chk("coll_cap", 64'({err_addr_vld, err_is_dbit, err_addr}), 64'h37F);
        chk("coll_irq", 64'(irq), 64'd1);

        // Fill to TWO, offer a refused dbit beat, then reset
        tick();
        out_ready = 1'b0;
        beat(1'b1, mk(6), 1'b1, 1'b0, 8'h01);
        tick();
        beat(1'b1, mk(7), 1'b1, 1'b0, 8'h02);
        tick();
        chk("two_ready", 64'(in_ready), 64'd0);
        chk("two_sbit", 64'(sbit_cnt), 64'd2);
        beat(1'b1, mk(8), 1'b0, 1'b1, 8'h03);
        tick();
        chk("refused_dbit", 64'(dbit_cnt), 64'd1);
        chk("refused_cap", 64'(err_addr), 64'h7F);
        rst = 1'b1;
        clr = 1'b1;
        tick();
        rst = 1'b0;
        clr = 1'b0;
        beat(1'b0, '0, 1'b0, 1'b0, '0);
        chk("rst2_out_valid", 64'(out_valid), 64'd0);
        chk("rst2_in_ready", 64'(in_ready), 64'd1);
        chk("rst2_cnts", 64'({sbit_cnt, dbit_cnt}), 64'd0);
        chk("rst2_flags", 64'({err_addr_vld, err_is_dbit, irq}), 64'd0);
        chk("rst2_data", 64'({out_poison, out_data}), 64'd0);
        tick();
        chk("rst2_stay_empty", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
